// File: rtl/mips_boot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_boot_pkg
// Description : Shared types and constants for the Mips boot loader.
//               Provides the loader state encoding, the image format
//               constants and a helper that reports which states accept
//               bytes from the input stream.
// Revision    : 1.0  initial release
// ============================================================================
package mips_boot_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    HOLD   = 3'd5,
    RUN    = 3'd6,
    ERR    = 3'd7
  } boot_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // States in which the byte stream is allowed to transfer.
  function automatic logic accepts_bytes(input boot_state_t s);
    return (s == HDR_HI) || (s == HDR_LO) || (s == DATA) || (s == CHECK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/boot_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : boot_word_assembler
// Description : Packs image data bytes into big-endian 32-bit words and keeps
//               the running XOR checksum of every data byte it has seen.
// Ports       : clk, rst        clock, asynchronous active-low reset
//               i_clr           synchronous clear of all state
//               i_byte_valid    a data byte is transferred this cycle
//               i_byte          the data byte
//               o_word_ready    this transfer completes a word
//               o_word          completed word (valid with o_word_ready)
//               o_checksum      XOR of all data bytes since the last clear
// Revision    : 1.0  initial release
// ============================================================================
module boot_word_assembler
  import mips_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_ready,
  output logic [31:0] o_word,
  output logic [7:0]  o_checksum
);

  localparam logic [1:0] c_LAST_IDX = 2'(BYTES_PER_WORD - 1);

  // Only the first three bytes of a word are stored; the fourth is taken
  // straight from the input so the word is available on its final transfer.
  logic [23:0] r_shift;
  logic [1:0]  r_idx;
  logic [7:0]  r_xor;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_xor   <= '0;
    end else if (i_clr) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_xor   <= '0;
    end else if (i_byte_valid) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_idx   <= (r_idx == c_LAST_IDX) ? 2'd0 : r_idx + 2'd1;
      r_xor   <= r_xor ^ i_byte;
    end
  end

  assign o_word_ready = i_byte_valid && (r_idx == c_LAST_IDX);
  assign o_word       = {r_shift, i_byte};
  assign o_checksum   = r_xor;

endmodule
`default_nettype wire

// File: rtl/mips_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : mips_boot_loader
// Description : Receives a program image over a valid/ready byte stream,
//               writes it word by word into instruction memory, verifies an
//               XOR checksum and releases the Mips core from reset after a
//               fixed hold-off.
// Ports       : clk, rst        clock, asynchronous active-low reset
//               start           begin a load (from IDLE, RUN or ERR)
//               rx_valid/ready  byte-stream handshake, rx_data payload
//               imem_we/addr/wdata  instruction-memory write port
//               core_rst        active-high reset to the core
//               done / error    load verified / load failed
//               words_loaded    words written in the current load
// Revision    : 1.0  initial release
// ============================================================================
module mips_boot_loader
  import mips_boot_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256,
  parameter int          RST_HOLD  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [16:0] c_DEPTH     = 17'(DEPTH);
  localparam logic [15:0] c_HOLD_LAST = 16'(RST_HOLD - 1);

  boot_state_t r_state;
  boot_state_t w_next_state;

  logic        r_rx_ready;
  logic        r_imem_we;
  logic [31:0] r_imem_addr;
  logic [31:0] r_imem_wdata;
  logic        r_core_rst;
  logic        r_done;
  logic        r_error;
  logic [15:0] r_words_loaded;
  logic [15:0] r_word_cnt;
  logic [15:0] r_n;
  logic [7:0]  r_cnt_hi;
  logic [15:0] r_hold;

  logic        w_xfer;
  logic        w_restart;
  logic        w_data_byte;
  logic [15:0] w_count;
  logic        w_last_word;
  logic        w_word_ready;
  logic [31:0] w_word;
  logic [7:0]  w_checksum;

  // rx_ready is registered from the next state, so it always reflects the
  // current state and a transfer is simply valid && ready.
  assign w_xfer      = rx_valid && r_rx_ready;
  assign w_restart   = start && ((r_state == IDLE) || (r_state == RUN) || (r_state == ERR));
  assign w_data_byte = w_xfer && (r_state == DATA);
  assign w_count     = {r_cnt_hi, rx_data};
  assign w_last_word = (16'(r_word_cnt + 16'd1) == r_n);

  boot_word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_restart),
    .i_byte_valid (w_data_byte),
    .i_byte       (rx_data),
    .o_word_ready (w_word_ready),
    .o_word       (w_word),
    .o_checksum   (w_checksum)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = HDR_HI;
      HDR_HI:  if (w_xfer) w_next_state = HDR_LO;
      HDR_LO: begin
        if (w_xfer) begin
          if ({1'b0, w_count} > c_DEPTH) w_next_state = ERR;
          else if (w_count == 16'd0)     w_next_state = CHECK;
          else                           w_next_state = DATA;
        end
      end
      DATA:    if (w_word_ready && w_last_word) w_next_state = CHECK;
      CHECK:   if (w_xfer) w_next_state = (rx_data == w_checksum) ? HOLD : ERR;
      HOLD:    if (r_hold == c_HOLD_LAST) w_next_state = RUN;
      RUN:     if (start) w_next_state = HDR_HI;
      ERR:     if (start) w_next_state = HDR_HI;
      default: w_next_state = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_ready     <= 1'b0;
      r_imem_we      <= 1'b0;
      r_imem_addr    <= BASE_ADDR;
      r_imem_wdata   <= '0;
      r_core_rst     <= 1'b1;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_words_loaded <= '0;
      r_word_cnt     <= '0;
      r_n            <= '0;
      r_cnt_hi       <= '0;
      r_hold         <= '0;
    end else begin
      r_rx_ready <= accepts_bytes(w_next_state);
      r_core_rst <= (w_next_state != RUN);
      r_done     <= (w_next_state == RUN);
      r_error    <= (w_next_state == ERR);
      r_imem_we  <= w_word_ready;
      r_hold     <= (r_state == HOLD) ? r_hold + 16'd1 : 16'd0;

      if ((r_state == HDR_HI) && w_xfer) r_cnt_hi <= rx_data;
      if ((r_state == HDR_LO) && w_xfer) r_n      <= w_count;

      if (w_restart) begin
        r_word_cnt     <= '0;
        r_words_loaded <= '0;
        r_imem_addr    <= BASE_ADDR;
      end else if (w_word_ready) begin
        r_imem_addr  <= BASE_ADDR + {14'b0, r_word_cnt, 2'b00};
        r_imem_wdata <= w_word;
        r_word_cnt   <= r_word_cnt + 16'd1;
        if ({1'b0, r_words_loaded} < c_DEPTH)
          r_words_loaded <= r_words_loaded + 16'd1;
      end
    end
  end

  assign rx_ready     = r_rx_ready;
  assign imem_we      = r_imem_we;
  assign imem_addr    = r_imem_addr;
  assign imem_wdata   = r_imem_wdata;
  assign core_rst     = r_core_rst;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words_loaded;

endmodule
`default_nettype wire

// File: tb/tb_mips_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_boot_loader
// Description : Self-checking bench for mips_boot_loader. Expected memory
//               writes are queued as images are sent and matched by a
//               monitor as write pulses appear.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mips_boot_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic [31:0] img[$];

  always #5 clk = ~clk;

  mips_boot_loader #(
    .BASE_ADDR (BASE),
    .DEPTH     (256),
    .RST_HOLD  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_rst     (core_rst),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  // Scoreboard monitor: every write pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && imem_we) begin
      n_writes++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", imem_addr, imem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== mon_exp) begin
          n_fail++;
          $display("FAIL imem_write: got addr=%h data=%h, required addr=%h data=%h",
                   imem_addr, imem_wdata, mon_exp[63:32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int t;
    if (stall) begin
      rx_valid = 1'b0;
      while ($urandom_range(1, 0) == 1) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      n_checks++; n_fail++;
      $display("FAIL handshake_timeout: rx_ready=%b required 1", rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Sends the image in img[]; start_at >= 0 pulses start with that data byte.
  task automatic send_image(input bit bad, input bit stall, input int start_at);
    logic [7:0]  ck;
    logic [15:0] n;
    logic [31:0] w;
    logic [7:0]  b;
    ck = 8'h00;
    n  = 16'(img.size());
    for (int i = 0; i < img.size(); i++) exp_q.push_back({BASE + 32'(4 * i), img[i]});
    send_byte(n[15:8], stall);
    send_byte(n[7:0], stall);
    for (int i = 0; i < img.size(); i++) begin
      w = img[i];
      for (int j = 3; j >= 0; j--) begin
        b  = w[8*j +: 8];
        ck = ck ^ b;
        if (i * 4 + (3 - j) == start_at) start = 1'b1;
        send_byte(b, stall);
        start = 1'b0;
      end
    end
    send_byte(bad ? (ck ^ 8'h01) : ck, stall);
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!(done || error) && t < 40) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready: got %b required 0", rx_ready); end
    n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_imem_we: got %b required 0", imem_we); end
    n_checks++; if (imem_addr !== BASE) begin n_fail++; $display("FAIL reset_imem_addr: got %h required %h", imem_addr, BASE); end
    n_checks++; if (imem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_imem_wdata: got %h required 0", imem_wdata); end
    n_checks++; if ({core_rst, done, error} !== 3'b100) begin n_fail++; $display("FAIL reset_status: got core_rst/done/error=%b required 100", {core_rst, done, error}); end
    n_checks++; if (words_loaded !== 16'd0) begin n_fail++; $display("FAIL reset_words_loaded: got %0d required 0", words_loaded); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    img = '{32'h2008_0005, 32'h0109_4020};
    do_start();
    n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL nominal_ready: got %b required 1", rx_ready); end
    send_image(1'b0, 1'b0, -1);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL nominal_hold: cycle %0d core_rst=%b required 1", i, core_rst); end
      @(negedge clk);
    end
    n_checks++; if ({core_rst, done, error} !== 3'b010) begin n_fail++; $display("FAIL nominal_release: got core_rst/done/error=%b required 010", {core_rst, done, error}); end
    n_checks++; if (words_loaded !== 16'd2) begin n_fail++; $display("FAIL nominal_words: got %0d required 2", words_loaded); end
    n_checks++; if (imem_addr !== BASE + 32'd4) begin n_fail++; $display("FAIL nominal_addr_held: got %h required %h", imem_addr, BASE + 32'd4); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL nominal_writes: %0d writes missing, required 0", exp_q.size()); end
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL nominal_run_ready: got %b required 0", rx_ready); end
  endtask

  task automatic test_reload_from_run();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL reload_pre_done: got %b required 1", done); end
    do_start();
    n_checks++; if ({core_rst, done, error} !== 3'b100) begin n_fail++; $display("FAIL reload_status: got core_rst/done/error=%b required 100", {core_rst, done, error}); end
    n_checks++; if ({words_loaded, imem_addr} !== {16'd0, BASE}) begin n_fail++; $display("FAIL reload_clear: got words=%0d addr=%h required 0 and %h", words_loaded, imem_addr, BASE); end
    send_image(1'b0, 1'b0, 5);
    wait_end();
    n_checks++; if ({done, error} !== 2'b10) begin n_fail++; $display("FAIL reload_done: got done/error=%b required 10", {done, error}); end
    n_checks++; if (words_loaded !== 16'd2) begin n_fail++; $display("FAIL reload_words: got %0d required 2", words_loaded); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL reload_writes: %0d writes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_bad_checksum();
    do_start();
    send_image(1'b1, 1'b0, -1);
    repeat (2) @(negedge clk);
    n_checks++; if ({core_rst, done, error} !== 3'b101) begin n_fail++; $display("FAIL badck_status: got core_rst/done/error=%b required 101", {core_rst, done, error}); end
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL badck_ready: got %b required 0", rx_ready); end
    do_start();
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL badck_restart_error: got %b required 0", error); end
    send_image(1'b0, 1'b0, -1);
    wait_end();
    n_checks++; if ({done, error} !== 2'b10) begin n_fail++; $display("FAIL badck_recover: got done/error=%b required 10", {done, error}); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL badck_writes: %0d writes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_oversize();
    int w0;
    w0 = n_writes;
    do_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    n_checks++; if ({error, rx_ready, core_rst} !== 3'b101) begin n_fail++; $display("FAIL oversize_err: got error/rx_ready/core_rst=%b required 101", {error, rx_ready, core_rst}); end
    repeat (4) @(negedge clk);
    n_checks++; if (n_writes != w0) begin n_fail++; $display("FAIL oversize_writes: got %0d writes required 0", n_writes - w0); end
  endtask

  task automatic test_empty();
    int w0;
    w0 = n_writes;
    img = {};
    do_start();
    send_image(1'b0, 1'b0, -1);
    wait_end();
    n_checks++; if ({core_rst, done, error} !== 3'b010) begin n_fail++; $display("FAIL empty_run: got core_rst/done/error=%b required 010", {core_rst, done, error}); end
    n_checks++; if (words_loaded !== 16'd0) begin n_fail++; $display("FAIL empty_words: got %0d required 0", words_loaded); end
    n_checks++; if (n_writes != w0) begin n_fail++; $display("FAIL empty_writes: got %0d writes required 0", n_writes - w0); end
  endtask

  task automatic test_stalls();
    int w0;
    w0 = n_writes;
    img = '{32'h2008_0005, 32'h0109_4020};
    do_start();
    send_image(1'b0, 1'b1, -1);
    wait_end();
    n_checks++; if ({done, error} !== 2'b10) begin n_fail++; $display("FAIL stall_done: got done/error=%b required 10", {done, error}); end
    n_checks++; if (words_loaded !== 16'd2) begin n_fail++; $display("FAIL stall_words: got %0d required 2", words_loaded); end
    n_checks++; if (n_writes - w0 != 2) begin n_fail++; $display("FAIL stall_write_count: got %0d required 2", n_writes - w0); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_writes: %0d writes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_midload();
    logic [7:0] part[$];
    part = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01};
    img = '{32'h2008_0005, 32'h0109_4020};
    do_start();
    exp_q.push_back({BASE, 32'h2008_0005});
    for (int i = 0; i < part.size(); i++) send_byte(part[i], 1'b0);
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({rx_ready, imem_we, core_rst, done, error} !== 5'b00100) begin n_fail++; $display("FAIL midrst_status: got ready/we/core_rst/done/error=%b required 00100", {rx_ready, imem_we, core_rst, done, error}); end
    n_checks++; if ({imem_addr, imem_wdata, words_loaded} !== {BASE, 32'h0, 16'd0}) begin n_fail++; $display("FAIL midrst_regs: got addr=%h data=%h words=%0d required %h 0 0", imem_addr, imem_wdata, words_loaded, BASE); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst_first_word: %0d writes missing, required 0", exp_q.size()); end
    do_start();
    send_image(1'b0, 1'b0, -1);
    wait_end();
    n_checks++; if ({done, error} !== 2'b10) begin n_fail++; $display("FAIL midrst_reload: got done/error=%b required 10", {done, error}); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst_writes: %0d writes missing, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_reload_from_run();
    test_bad_checksum();
    test_oversize();
    test_empty();
    test_stalls();
    test_reset_midload();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
